// File: rtl/par_frame_rx_if.sv
// par_frame_rx_if: serial link bundle between a bit source and the parity
// frame receiver.
//   bit_en    - bit strobe, sin is only meaningful when high
//   sin       - serial line, idles high
//   data_out  - last reassembled data word
//   valid     - one-cycle frame-complete pulse
//   par_err   - parity mismatch, coincident with valid
//   frame_err - stop bit was 0, coincident with valid
//   busy      - receiver is inside a frame
// master drives the line, slave is the receiver.
interface par_frame_rx_if #(
  parameter int N = 3
);
  logic         bit_en;
  logic         sin;
  logic [N-1:0] data_out;
  logic         valid;
  logic         par_err;
  logic         frame_err;
  logic         busy;

  modport master (
    output bit_en, sin,
    input  data_out, valid, par_err, frame_err, busy
  );

  modport slave (
    input  bit_en, sin,
    output data_out, valid, par_err, frame_err, busy
  );
endinterface

// File: rtl/par_frame_rx.sv
// par_frame_rx: receives start / N data bits (LSB first) / parity / stop,
// reassembles the word and flags parity and framing errors.
//   i_clk  - system clock, rising edge
//   i_rst  - synchronous active-high reset
//   bus    - par_frame_rx_if slave: bit_en, sin in; data_out, valid,
//            par_err, frame_err, busy out
//
// state  | meaning
// -------+--------------------------------------------------
// IDLE   | line idle, waiting for a 0 start bit
// DATA   | shifting in N data bits, accumulating parity
// PARITY | comparing received parity bit with running parity
// STOP   | sampling stop bit, publishing word and error flags
module par_frame_rx #(
  parameter int N   = 3,
  parameter bit ODD = 1'b0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  par_frame_rx_if.slave  bus
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_shift;
  logic           r_par;
  logic           r_perr;
  logic [N-1:0]   r_data_out;
  logic           r_valid;
  logic           r_par_err;
  logic           r_frame_err;

  logic           w_busy;
  logic           w_start;
  logic           w_shift;
  logic           w_cap_par;
  logic           w_stop;
  logic [N:0]     w_shift_cat;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic: nothing moves without a bit strobe
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.bit_en && !bus.sin)                w_state_nxt = S_DATA;
      S_DATA:   if (bus.bit_en && (r_cnt == CW'(N - 1)))   w_state_nxt = S_PARITY;
      S_PARITY: if (bus.bit_en)                            w_state_nxt = S_STOP;
      S_STOP:   if (bus.bit_en)                            w_state_nxt = S_IDLE;
      default:                                             w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath-control decode
  always_comb begin
    w_busy    = 1'b0;
    w_start   = 1'b0;
    w_shift   = 1'b0;
    w_cap_par = 1'b0;
    w_stop    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_start = bus.bit_en && !bus.sin;
      end
      S_DATA: begin
        w_busy  = 1'b1;
        w_shift = bus.bit_en;
      end
      S_PARITY: begin
        w_busy    = 1'b1;
        w_cap_par = bus.bit_en;
      end
      S_STOP: begin
        w_busy = 1'b1;
        w_stop = bus.bit_en;
      end
      default: ;
    endcase
  end

  // Right shift: new bit enters at the MSB so the first data bit ends in bit 0
  assign w_shift_cat = {bus.sin, r_shift};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_perr      <= 1'b0;
      r_data_out  <= '0;
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      // Seeding the running parity with ODD makes a mismatch read as 1 in both senses
      if (w_start) begin
        r_cnt <= '0;
        r_par <= ODD;
      end
      if (w_shift) begin
        r_shift <= w_shift_cat[N:1];
        r_par   <= r_par ^ bus.sin;
        r_cnt   <= r_cnt + CW'(1);
      end
      if (w_cap_par) begin
        r_perr <= r_par ^ bus.sin;
      end
      if (w_stop) begin
        r_data_out  <= r_shift;
        r_valid     <= 1'b1;
        r_par_err   <= r_perr;
        r_frame_err <= ~bus.sin;
      end
    end
  end

  assign bus.data_out  = r_data_out;
  assign bus.valid     = r_valid;
  assign bus.par_err   = r_par_err;
  assign bus.frame_err = r_frame_err;
  assign bus.busy      = w_busy;

endmodule

// File: doc/par_frame_rx.md
Name: par_frame_rx

Overview:
- Downstream consumer of the parity generator's output.
- Receives a serial frame of N data bits plus the generated parity bit and checks it.
- Frame format: start bit, data (LSB first), parity, stop bit.
- Reassembles the data word, then reports parity and framing errors.
- Sits at the receive end of the parity-protected link in the Ch03 modeling examples.

Parameters:
- N, 3, data bits per frame (3 matches the a/b/c parity generator).
- ODD, 0, parity sense: 0 = even (data XOR parity = 0), 1 = odd (data XOR parity = 1).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- bit_en  input  1  bit strobe. Sin is sampled only on cycles with bit_en=1.
- sin  input  1  serial line. Idle level is 1.
- data_out  output  N  last received data word. Held until the next frame completes.
- valid  output  1  one-cycle pulse when a frame completes.
- par_err  output  1  one-cycle pulse coincident with valid. Parity mismatch.
- frame_err  output  1  one-cycle pulse coincident with valid. Stop bit was 0.
- busy  output  1  high while the FSM is outside IDLE.

Behaviour:
- Interface: one clock (clk). Reset rst is synchronous and active-high.
- Reset: on the next clk edge with rst=1, state=IDLE and all of the following clear to 0:
  - data_out, valid, par_err, frame_err, busy;
  - the shift register, bit counter and running parity.
- Reset has priority over every other input, including mid-frame. A frame in progress is discarded and no valid is produced.
- Sampling: all FSM activity occurs only on clk edges where bit_en=1. With bit_en=0 the state, counter and shift register hold, and valid/par_err/frame_err are 0.
- State IDLE:
  - sin=0 on a bit_en cycle starts a frame: go to DATA, cnt=0, running parity=ODD.
  - sin=1: stay in IDLE.
- State DATA:
  - Each bit_en cycle shifts sin in at the MSB side (right shift), so the first bit received lands in data bit 0.
  - The running parity is XORed with sin on each bit.
  - cnt increments each bit. After N bits (cnt=N-1 sampled), go to PARITY.
- State PARITY:
  - Capture perr = running_parity XOR sin.
  - perr=1 means mismatch: even mode requires data XOR parity = 0; odd mode requires 1.
  - Go to STOP.
- State STOP:
  - Sample sin. ferr = ~sin.
  - On the same edge, load data_out from the shift register.
  - Assert valid=1, par_err=perr and frame_err=ferr for exactly one clk cycle (registered, visible the cycle after the stop sample).
  - Return to IDLE.
- Valid and errors: valid is asserted even when errors are present. Both errors can be set simultaneously.
- Latency: valid rises 1 clk after the edge that samples the stop bit. Frame length is N+3 bit_en strobes.
- Back-to-back frames: a start bit on the bit_en strobe immediately after STOP is accepted. No idle bit is required.
- Start-bit qualification: the start bit is not re-qualified. A single 0 in IDLE starts a frame.
- bit_en held at 1 continuously: one bit per clk, which is legal.
- Counter: width $clog2(N)+1. It never wraps within a frame and is cleared on frame start.
- busy: 1 in DATA/PARITY/STOP, 0 in IDLE.

Test Plan:
1. Reset then idle: rst=1 for 2 clk, sin=1, bit_en=1 for 10 clk -> all outputs 0, busy=0 throughout.
2. Good even frame, N=3, ODD=0, bit_en=1 continuously. Send start 0, data bits 1,0,1 (word 3'b101), parity 0, stop 1 -> one cycle with valid=1, data_out=3'b101, par_err=0, frame_err=0.
3. All 8 a/b/c combinations: drive data 000..111 with parity a^b^c and stop 1 -> 8 valid pulses with matching data_out and par_err=0. Repeat with the parity bit inverted -> par_err=1 on every frame.
4. Bad stop: data 3'b011, parity 0, stop 0 -> valid=1, data_out=3'b011, frame_err=1, par_err=0. Then data 3'b011, parity 1, stop 0 -> par_err=1 and frame_err=1 together.
5. Sparse bit_en: bit_en=1 every 4th clk, frame 3'b110 with parity 0 -> state holds between strobes. valid appears 1 clk after the 6th strobe, data_out=3'b110.
6. Reset mid-frame and back-to-back:
   - Assert rst after the 2nd data bit -> no valid, busy=0.
   - Then send two consecutive frames (3'b001/p=1, 3'b111/p=1) with no idle bit between them -> two valid pulses, data_out 3'b001 then 3'b111, no errors.
